// File: rtl/sfu_acc_bank.sv
// Per-column accumulation buffer with saturating in-place add, optional ReLU on
// the final pass, a single valid/ready output register and sticky saturation flags.

module sfu_acc_lane #(
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int aw      = $clog2(depth)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_acc,
  input  logic               i_first,
  input  logic               i_emit,
  input  logic               i_drop,
  input  logic               i_relu_en,
  input  logic               i_clr_flag,
  input  logic [aw-1:0]      i_addr,
  input  logic [psum_bw-1:0] i_din,
  output logic [psum_bw-1:0] o_data,
  output logic               o_sat
);
  logic [psum_bw-1:0] r_mem [depth];
  logic [psum_bw-1:0] r_data;
  logic               r_sat;
  logic [psum_bw-1:0] w_m, w_new, w_out;
  logic [psum_bw:0]   w_sum;
  logic               w_ovf, w_sat;

  // Sum one bit wider; disagreement of the top two bits means overflow.
  always_comb begin
    w_m   = r_mem[i_addr];
    w_sum = {w_m[psum_bw-1], w_m} + {i_din[psum_bw-1], i_din};
    w_ovf = w_sum[psum_bw] ^ w_sum[psum_bw-1];
    w_new = w_sum[psum_bw-1:0];
    if (i_first)
      w_new = i_din;
    else if (w_ovf)
      w_new = w_sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    w_sat = i_acc && !i_first && w_ovf;
    w_out = (i_relu_en && w_new[psum_bw-1]) ? '0 : w_new;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < depth; k++) r_mem[k] <= '0;
      r_data <= '0;
      r_sat  <= 1'b0;
    end else begin
      if (i_acc) r_mem[i_addr] <= w_new;
      if (i_emit)      r_data <= w_out;
      else if (i_drop) r_data <= '0;
      if (w_sat)           r_sat <= 1'b1;
      else if (i_clr_flag) r_sat <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_sat  = r_sat;
endmodule

module sfu_acc_bank #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 16,
  parameter int aw      = $clog2(depth)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [psum_bw*col-1:0] i_in_data,
  input  logic [aw-1:0]          i_in_addr,
  input  logic                   i_first,
  input  logic                   i_last,
  input  logic                   i_relu_en,
  input  logic                   i_clr_flags,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [psum_bw*col-1:0] o_out_data,
  output logic [aw-1:0]          o_out_addr,
  output logic [col-1:0]         o_sat_flag
);
  logic [col-1:0][psum_bw-1:0] w_din, w_dout;
  logic                        r_out_valid;
  logic [aw-1:0]               r_out_addr;
  logic                        w_acc, w_emit, w_drop;

  assign o_in_ready = !r_out_valid || i_out_ready;
  assign w_acc      = i_in_valid && o_in_ready;
  assign w_emit     = w_acc && i_last;
  // A fresh last beat overrides the handshake clear, so outputs stream without a bubble.
  assign w_drop     = r_out_valid && i_out_ready && !w_emit;
  assign w_din      = i_in_data;

  for (genvar g = 0; g < col; g++) begin : g_lane
    sfu_acc_lane #(.psum_bw(psum_bw), .depth(depth), .aw(aw)) u_lane (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_acc      (w_acc),
      .i_first    (i_first),
      .i_emit     (w_emit),
      .i_drop     (w_drop),
      .i_relu_en  (i_relu_en),
      .i_clr_flag (i_clr_flags),
      .i_addr     (i_in_addr),
      .i_din      (w_din[g]),
      .o_data     (w_dout[g]),
      .o_sat      (o_sat_flag[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_addr  <= i_in_addr;
    end else if (w_drop) begin
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_addr  = r_out_addr;
  assign o_out_data  = w_dout;
endmodule

// File: tb/tb_sfu_acc_bank.sv
// Directed and randomized checks of sfu_acc_bank against an integer-arithmetic model.

module tb_sfu_acc_bank;
  localparam int PB = 16, NC = 8, DP = 16, AW = 4;

  logic              clk = 1'b0, rst = 1'b0;
  logic              in_valid = 0, in_ready, first = 0, last = 0, relu_en = 0, clr_flags = 0;
  logic              out_valid, out_ready = 1;
  logic [PB*NC-1:0]  in_data = '0, out_data;
  logic [AW-1:0]     in_addr = '0, out_addr;
  logic [NC-1:0]     sat_flag;

  always #5 clk = ~clk;

  sfu_acc_bank #(.psum_bw(PB), .col(NC), .depth(DP)) dut (
    .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_addr(in_addr), .i_first(first), .i_last(last),
    .i_relu_en(relu_en), .i_clr_flags(clr_flags), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_data(out_data), .o_out_addr(out_addr),
    .o_sat_flag(sat_flag)
  );

  int n_pass = 0, n_tot = 0;

  // reference model state
  int          m_mem [DP][NC];
  bit [NC-1:0] m_sat;
  bit          m_ov;
  int          m_od [NC];
  int          m_oa;

  bit s_v, s_f, s_l, s_r, s_c, s_ordy;
  int s_a;
  int s_d [NC];

  function automatic int lane(input int i);
    return int'($signed(out_data[PB*i +: PB]));
  endfunction

  task automatic set_all(input int x);
    for (int i = 0; i < NC; i++) s_d[i] = x;
  endtask

  task automatic drive(input bit v, f, l, r, c, input int a, input bit ordy);
    s_v = v; s_f = f; s_l = l; s_r = r; s_c = c; s_a = a; s_ordy = ordy;
    in_valid = v; first = f; last = l; relu_en = r; clr_flags = c;
    in_addr = a[AW-1:0]; out_ready = ordy;
    for (int i = 0; i < NC; i++) in_data[PB*i +: PB] = s_d[i][PB-1:0];
  endtask

  task automatic step();
    bit acc;
    int nv;
    bit [NC-1:0] ev;
    acc = s_v && (!m_ov || s_ordy);
    @(posedge clk); #1;
    ev = '0;
    if (acc) begin
      for (int i = 0; i < NC; i++) begin
        if (s_f) nv = s_d[i];
        else begin
          nv = m_mem[s_a][i] + s_d[i];
          if (nv > 32767)       begin nv = 32767;  ev[i] = 1'b1; end
          else if (nv < -32768) begin nv = -32768; ev[i] = 1'b1; end
        end
        m_mem[s_a][i] = nv;
        if (s_l) m_od[i] = (s_r && nv < 0) ? 0 : nv;
      end
    end
    m_sat = (s_c ? '0 : m_sat) | ev;
    if (acc && s_l) begin m_ov = 1'b1; m_oa = s_a; end
    else if (m_ov && s_ordy) m_ov = 1'b0;
  endtask

  task automatic beat(input bit v, f, l, r, c, input int a, input bit ordy);
    drive(v, f, l, r, c, a, ordy);
    step();
  endtask

  task automatic do_reset();
    set_all(1234);
    drive(1, 1, 1, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < DP; k++) for (int i = 0; i < NC; i++) m_mem[k][i] = 0;
    for (int i = 0; i < NC; i++) m_od[i] = 0;
    m_sat = '0; m_ov = 1'b0; m_oa = 0;
    set_all(0);
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    do_reset();
    n_tot++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_tot++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
    n_tot++; if (out_addr !== '0) $display("FAIL reset_out_addr got %0d want 0", out_addr); else n_pass++;
    n_tot++; if (sat_flag !== '0) $display("FAIL reset_sat got %h want 0", sat_flag); else n_pass++;
    n_tot++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_first_last();
    set_all(100);
    beat(1, 1, 1, 0, 0, 3, 1);
    n_tot++; if (out_valid !== 1'b1) $display("FAIL fl_valid got %b want 1", out_valid); else n_pass++;
    n_tot++; if (out_addr !== 4'd3) $display("FAIL fl_addr got %0d want 3", out_addr); else n_pass++;
    for (int i = 0; i < NC; i++) begin
      n_tot++; if (lane(i) !== 100) $display("FAIL fl_lane%0d got %0d want 100", i, lane(i)); else n_pass++;
    end
    beat(0, 0, 0, 0, 0, 0, 1);
    n_tot++; if (out_valid !== 1'b0) $display("FAIL fl_drain got %b want 0", out_valid); else n_pass++;
    set_all(0);
    beat(1, 0, 1, 0, 0, 3, 1);
    n_tot++; if (lane(4) !== 100) $display("FAIL fl_mem3 got %0d want 100", lane(4)); else n_pass++;
  endtask

  task automatic test_accum();
    set_all(10); beat(1, 1, 0, 0, 0, 5, 1);
    n_tot++; if (out_valid !== 1'b0) $display("FAIL acc_nout1 got %b want 0", out_valid); else n_pass++;
    set_all(20); beat(1, 0, 0, 0, 0, 5, 1);
    n_tot++; if (out_valid !== 1'b0) $display("FAIL acc_nout2 got %b want 0", out_valid); else n_pass++;
    set_all(-5); beat(1, 0, 1, 0, 0, 5, 1);
    n_tot++; if (out_valid !== 1'b1) $display("FAIL acc_valid got %b want 1", out_valid); else n_pass++;
    for (int i = 0; i < NC; i++) begin
      n_tot++; if (lane(i) !== 25) $display("FAIL acc_lane%0d got %0d want 25", i, lane(i)); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    set_all(32000); beat(1, 1, 0, 0, 0, 6, 1);
    set_all(1000);  beat(1, 0, 1, 0, 0, 6, 1);
    n_tot++; if (lane(0) !== 32767) $display("FAIL sat_pos got %0d want 32767", lane(0)); else n_pass++;
    n_tot++; if (lane(7) !== 32767) $display("FAIL sat_pos7 got %0d want 32767", lane(7)); else n_pass++;
    n_tot++; if (sat_flag !== 8'hFF) $display("FAIL sat_flag_pos got %h want ff", sat_flag); else n_pass++;
    beat(0, 0, 0, 0, 1, 0, 1);
    n_tot++; if (sat_flag !== 8'h00) $display("FAIL sat_clr got %h want 00", sat_flag); else n_pass++;
    set_all(-32000); beat(1, 1, 0, 0, 0, 6, 1);
    set_all(-1000);  beat(1, 0, 1, 0, 0, 6, 1);
    n_tot++; if (lane(3) !== -32768) $display("FAIL sat_neg got %0d want -32768", lane(3)); else n_pass++;
    n_tot++; if (sat_flag !== 8'hFF) $display("FAIL sat_flag_neg got %h want ff", sat_flag); else n_pass++;
    // clear and a new saturation in the same cycle: the flag must stay set
    set_all(-1000); beat(1, 0, 0, 0, 1, 6, 1);
    n_tot++; if (sat_flag !== 8'hFF) $display("FAIL sat_clr_race got %h want ff", sat_flag); else n_pass++;
    beat(0, 0, 0, 0, 1, 0, 1);
    n_tot++; if (sat_flag !== 8'h00) $display("FAIL sat_clr2 got %h want 00", sat_flag); else n_pass++;
  endtask

  task automatic test_relu();
    set_all(0); s_d[0] = -7; s_d[1] = 9;
    beat(1, 1, 1, 1, 0, 7, 1);
    n_tot++; if (lane(0) !== 0) $display("FAIL relu_l0 got %0d want 0", lane(0)); else n_pass++;
    n_tot++; if (lane(1) !== 9) $display("FAIL relu_l1 got %0d want 9", lane(1)); else n_pass++;
    set_all(0);
    beat(1, 0, 1, 0, 0, 7, 1);
    n_tot++; if (lane(0) !== -7) $display("FAIL relu_raw got %0d want -7", lane(0)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    beat(0, 0, 0, 0, 0, 0, 1);
    set_all(7); beat(1, 1, 1, 0, 0, 9, 0);
    n_tot++; if (out_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", out_valid); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      set_all(50); drive(1, 0, 1, 0, 0, 9, 0); #1;
      n_tot++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else n_pass++;
      step();
      n_tot++; if (lane(2) !== 7 || out_addr !== 4'd9) $display("FAIL bp_hold got %0d@%0d want 7@9", lane(2), out_addr); else n_pass++;
    end
    set_all(3); drive(1, 1, 1, 0, 0, 10, 1); #1;
    n_tot++; if (in_ready !== 1'b1) $display("FAIL bp_release got %b want 1", in_ready); else n_pass++;
    step();
    n_tot++; if (out_valid !== 1'b1 || lane(5) !== 3 || out_addr !== 4'd10)
      $display("FAIL b2b got v%b %0d@%0d want v1 3@10", out_valid, lane(5), out_addr); else n_pass++;
    set_all(0); beat(1, 0, 1, 0, 0, 9, 1);
    n_tot++; if (lane(1) !== 7) $display("FAIL bp_mem_kept got %0d want 7", lane(1)); else n_pass++;
    beat(0, 0, 0, 0, 0, 0, 1);
    n_tot++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    set_all(32767); beat(1, 1, 0, 0, 0, 1, 1);
    set_all(5);     beat(1, 0, 1, 0, 0, 1, 0);
    n_tot++; if (out_valid !== 1'b1 || sat_flag !== 8'hFF) $display("FAIL rm_pre got v%b s%h want v1 sff", out_valid, sat_flag); else n_pass++;
    do_reset();
    n_tot++; if (out_valid !== 1'b0) $display("FAIL rm_valid got %b want 0", out_valid); else n_pass++;
    n_tot++; if (sat_flag !== 8'h00) $display("FAIL rm_sat got %h want 00", sat_flag); else n_pass++;
    set_all(4); beat(1, 0, 1, 0, 0, 2, 1);
    n_tot++; if (lane(6) !== 4) $display("FAIL rm_emit got %0d want 4", lane(6)); else n_pass++;
    set_all(0); beat(1, 0, 1, 0, 0, 1, 1);
    n_tot++; if (lane(0) !== 0) $display("FAIL rm_mem_zero got %0d want 0", lane(0)); else n_pass++;
    set_all(0); beat(1, 0, 1, 0, 0, 0, 1);
    n_tot++; if (lane(0) !== 0) $display("FAIL rm_discard got %0d want 0", lane(0)); else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NC; i++)
        s_d[i] = ($urandom_range(1) == 1) ? int'($urandom_range(65535)) - 32768
                                           : int'($urandom_range(100)) - 50;
      drive($urandom_range(3) != 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
            $urandom_range(1) == 1, $urandom_range(7) == 0, int'($urandom_range(3)),
            $urandom_range(2) != 0);
      #1;
      n_tot++; if (in_ready !== (!m_ov || s_ordy)) $display("FAIL rnd_in_ready[%0d] got %b want %b", n, in_ready, !m_ov || s_ordy); else n_pass++;
      step();
      n_tot++; if (out_valid !== m_ov) $display("FAIL rnd_valid[%0d] got %b want %b", n, out_valid, m_ov); else n_pass++;
      n_tot++; if (sat_flag !== m_sat) $display("FAIL rnd_sat[%0d] got %h want %h", n, sat_flag, m_sat); else n_pass++;
      if (m_ov) begin
        n_tot++; if (out_addr !== m_oa[AW-1:0]) $display("FAIL rnd_addr[%0d] got %0d want %0d", n, out_addr, m_oa); else n_pass++;
        for (int i = 0; i < NC; i++) begin
          n_tot++; if (lane(i) !== m_od[i]) $display("FAIL rnd_lane%0d[%0d] got %0d want %0d", i, n, lane(i), m_od[i]); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    set_all(0);
    test_reset();
    test_first_last();
    test_accum();
    test_saturation();
    test_relu();
    test_back_to_back();
    test_reset_mid();
    do_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
